// File: rtl/shifter_pipe_pkg.sv
// Shared types and stage-placement helpers for the pipelined barrel shifter.
package shifter_pkg;

  localparam int unsigned SH_MODE_W = 2;

  typedef enum logic [SH_MODE_W-1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_t;

  // Pipeline stage that owns mux level k.
  function automatic int unsigned stage_of_level(input int unsigned k,
                                                 input int unsigned shamt_w,
                                                 input int unsigned pipe_stages);
    return (k * pipe_stages) / shamt_w;
  endfunction

  // True when level k is the first level evaluated in its stage.
  function automatic bit level_starts_stage(input int unsigned k,
                                            input int unsigned shamt_w,
                                            input int unsigned pipe_stages);
    if (k == 0) return 1'b1;
    return stage_of_level(k - 1, shamt_w, pipe_stages) != stage_of_level(k, shamt_w, pipe_stages);
  endfunction

  // True when level k is the last level before its stage register.
  function automatic bit level_ends_stage(input int unsigned k,
                                          input int unsigned shamt_w,
                                          input int unsigned pipe_stages);
    if (k + 1 >= shamt_w) return 1'b1;
    return stage_of_level(k + 1, shamt_w, pipe_stages) != stage_of_level(k, shamt_w, pipe_stages);
  endfunction

endpackage

// File: rtl/shifter_pipe_level.sv
// One barrel-shifter mux level: shifts by DIST when en is set.
// Rotate support is built only when SHIFTER_PIPE_ROTATE_EN is defined;
// otherwise mode SH_ROR behaves as SLL.
module shifter_level
  import shifter_pkg::*;
#(
  parameter int unsigned WORD = 32,
  parameter int unsigned DIST = 1
) (
  input  logic [WORD-1:0] data_i,
  input  logic            en,
  input  shift_mode_t     mode,
  output logic [WORD-1:0] data_o
);

  // Select shifted or unshifted word for this level.
  always_comb begin
    data_o = data_i;
    if (en) begin
      case (mode)
        SH_SLL: data_o = data_i << DIST;
        SH_SRL: data_o = data_i >> DIST;
        SH_SRA: data_o = $signed(data_i) >>> DIST;
`ifdef SHIFTER_PIPE_ROTATE_EN
        SH_ROR: data_o = {data_i[DIST-1:0], data_i[WORD-1:DIST]};
`else
        SH_ROR: data_o = data_i << DIST;
`endif
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROR) with valid/ready
// backpressure and a pass-through tag. Optional rotate: SHIFTER_PIPE_ROTATE_EN.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int unsigned WORD        = 32,
  parameter int unsigned SHAMT_W     = $clog2(WORD),
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD-1:0]      in_data,
  input  logic [SHAMT_W-1:0]   in_shamt,
  input  logic [SH_MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      out_data,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned LAST = PIPE_STAGES - 1;

  logic [PIPE_STAGES-1:0] v_q, v_d;
  logic [WORD-1:0]        data_q  [PIPE_STAGES];
  logic [WORD-1:0]        data_d  [PIPE_STAGES];
  logic [SHAMT_W-1:0]     shamt_q [PIPE_STAGES];
  logic [SHAMT_W-1:0]     shamt_d [PIPE_STAGES];
  shift_mode_t            mode_q  [PIPE_STAGES];
  shift_mode_t            mode_d  [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q   [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_d   [PIPE_STAGES];

  logic [WORD-1:0]        stg_data_in  [PIPE_STAGES];
  logic [SHAMT_W-1:0]     stg_shamt_in [PIPE_STAGES];
  shift_mode_t            stg_mode_in  [PIPE_STAGES];
  logic [TAG_W-1:0]       stg_tag_in   [PIPE_STAGES];
  logic [WORD-1:0]        stg_data_out [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] adv, ld;
  logic                   down_ok, up_ld;

  // Stage s is fed by the input port (s = 0) or by the previous stage register.
  always_comb begin
    stg_data_in[0]  = in_data;
    stg_shamt_in[0] = in_shamt;
    stg_mode_in[0]  = shift_mode_t'(in_mode);
    stg_tag_in[0]   = in_tag;
    for (int s = 1; s < int'(PIPE_STAGES); s++) begin
      stg_data_in[s]  = data_q[s-1];
      stg_shamt_in[s] = shamt_q[s-1];
      stg_mode_in[s]  = mode_q[s-1];
      stg_tag_in[s]   = tag_q[s-1];
    end
  end

  // Mux levels, chained within a stage and split at stage boundaries.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_lvl
    localparam int unsigned ST = stage_of_level(k, SHAMT_W, PIPE_STAGES);
    logic [WORD-1:0] d_in;
    logic [WORD-1:0] d_out;

    if (level_starts_stage(k, SHAMT_W, PIPE_STAGES)) begin : g_head
      assign d_in = stg_data_in[ST];
    end else begin : g_chain
      assign d_in = g_lvl[k-1].d_out;
    end

    shifter_level #(
      .WORD (WORD),
      .DIST (1 << k)
    ) u_level (
      .data_i (d_in),
      .en     (stg_shamt_in[ST][k]),
      .mode   (stg_mode_in[ST]),
      .data_o (d_out)
    );

    if (level_ends_stage(k, SHAMT_W, PIPE_STAGES)) begin : g_tail
      assign stg_data_out[ST] = d_out;
    end
  end

  // Backpressure chain from out_ready toward the input, then load enables forward.
  always_comb begin
    adv     = '0;
    ld      = '0;
    down_ok = out_ready;
    up_ld   = 1'b0;
    for (int i = int'(PIPE_STAGES) - 1; i >= 0; i--) begin
      adv[i]  = v_q[i] & down_ok;
      down_ok = ~v_q[i] | adv[i];
    end
    in_ready = down_ok;
    up_ld    = in_valid & down_ok;
    for (int i = 0; i < int'(PIPE_STAGES); i++) begin
      ld[i] = up_ld;
      up_ld = adv[i];
    end
  end

  // Next-state for each stage: load on transfer, hold otherwise; flush empties all.
  always_comb begin
    v_d = '0;
    for (int s = 0; s < int'(PIPE_STAGES); s++) begin
      v_d[s]     = ~flush & (ld[s] | (v_q[s] & ~adv[s]));
      data_d[s]  = data_q[s];
      shamt_d[s] = shamt_q[s];
      mode_d[s]  = mode_q[s];
      tag_d[s]   = tag_q[s];
      if (ld[s]) begin
        data_d[s]  = stg_data_out[s];
        shamt_d[s] = stg_shamt_in[s];
        mode_d[s]  = stg_mode_in[s];
        tag_d[s]   = stg_tag_in[s];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s < int'(PIPE_STAGES); s++) begin
        data_q[s]  <= '0;
        shamt_q[s] <= '0;
        mode_q[s]  <= SH_SLL;
        tag_q[s]   <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int s = 0; s < int'(PIPE_STAGES); s++) begin
        data_q[s]  <= data_d[s];
        shamt_q[s] <= shamt_d[s];
        mode_q[s]  <= mode_d[s];
        tag_q[s]   <= tag_d[s];
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_shifter_pipe.sv
// Bench for shifter_pipe: vector table, scoreboard, stall/flush/reset sequences.
module tb_shifter_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  shifter_pipe #(
    .WORD        (32),
    .PIPE_STAGES (2),
    .TAG_W       (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } sb_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  sb_t         sb[$];
  vec_t        vecs[12];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_in;
  logic        acc_fire;
  logic        out_fire;

  // Reference shifter written independently of the level structure.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] n,
                                        input logic [1:0] m);
    logic [31:0] r;
    case (m)
      2'b00: r = d << n;
      2'b01: r = d >> n;
      2'b10: r = 32'($signed(d) >>> n);
`ifdef SHIFTER_PIPE_ROTATE_EN
      default: r = (n == 5'd0) ? d : ((d >> n) | (d << (6'd32 - 6'(n))));
`else
      default: r = d << n;
`endif
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: sample handshakes away from the rising edge, update scoreboard,
  // then advance to the next falling edge where new inputs are driven.
  task automatic tick();
    sb_t e;
    #1;
    acc_fire = in_valid & in_ready & ~flush;
    out_fire = out_valid & out_ready;
    if (out_fire) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got tag %0d data %h expected no output", out_tag, out_data);
      end else begin
        e = sb.pop_front();
        chk("sb_data", out_data, e.data);
        chk("sb_tag", 32'(out_tag), 32'(e.tag));
      end
    end
    if (flush) sb.delete();
    if (acc_fire) sb.push_back('{exp_in, in_tag});
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] n,
                       input logic [1:0] m, input logic [4:0] t);
    in_valid = v;
    in_data  = d;
    in_shamt = n;
    in_mode  = m;
    in_tag   = t;
    exp_in   = model(d, n, m);
  endtask

  task automatic drain();
    int budget;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 0;
    while ((sb.size() != 0 || out_valid) && budget < 50) begin
      tick();
      budget++;
    end
    chk("drain_done", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int i, budget, n_acc, n_out;
    logic [31:0] ror_exp;
`ifdef SHIFTER_PIPE_ROTATE_EN
    ror_exp = 32'h1000_000F;
`else
    ror_exp = 32'h0000_0F10;
`endif
    vecs[0]  = '{32'h8000_0000, 5'd31, 2'b10, 5'd1,  32'hFFFF_FFFF};
    vecs[1]  = '{32'h8000_0000, 5'd31, 2'b01, 5'd2,  32'h0000_0001};
    vecs[2]  = '{32'h7FFF_FFFF, 5'd31, 2'b10, 5'd3,  32'h0000_0000};
    vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 5'd4,  32'hDEAD_BEEF};
    vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 5'd5,  32'hDEAD_BEEF};
    vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 5'd6,  32'hDEAD_BEEF};
    vecs[6]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 5'd7,  32'hDEAD_BEEF};
    vecs[7]  = '{32'hFFFF_FFFF, 5'd31, 2'b00, 5'd8,  32'h8000_0000};
    vecs[8]  = '{32'hF000_0000, 5'd4,  2'b01, 5'd9,  32'h0F00_0000};
    vecs[9]  = '{32'hF000_0000, 5'd4,  2'b10, 5'd10, 32'hFF00_0000};
    vecs[10] = '{32'h8000_0000, 5'd1,  2'b10, 5'd11, 32'hC000_0000};
    vecs[11] = '{32'h0000_00F1, 5'd4,  2'b11, 5'd12, ror_exp};

    // Reset state.
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 2'b00, 5'd0);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Constant-offset SLL: result exactly two cycles after accept.
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_0001, 5'd2, 2'b00, 5'd3);
    tick();
    chk("lat_accept", 32'(acc_fire), 32'd1);
    in_valid = 1'b0;
    #1;
    chk("lat_c1_valid", 32'(out_valid), 32'd0);
    tick();
    #1;
    chk("lat_c2_valid", 32'(out_valid), 32'd1);
    chk("lat_c2_data", out_data, 32'h0000_0004);
    tick();

    // Vector table, back-to-back.
    i = 0; budget = 0;
    while (i < 12 && budget < 100) begin
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      in_shamt = vecs[i].shamt;
      in_mode  = vecs[i].mode;
      in_tag   = vecs[i].tag;
      exp_in   = vecs[i].exp;
      tick();
      if (acc_fire) i++;
      budget++;
    end
    chk("table_accepted", 32'(i), 32'd12);
    drain();

    // Stall: tags 1..8 back-to-back, out_ready low for five cycles.
    n_acc = 0; n_out = 0;
    for (int cyc = 0; cyc < 40 && n_out < 8; cyc++) begin
      drive(n_acc < 8, 32'h1, 5'(n_acc + 1), 2'b00, 5'(n_acc + 1));
      out_ready = (cyc >= 5);
      #1;
      if (cyc < 5) chk("stall_in_ready", 32'(in_ready), (cyc < 2) ? 32'd1 : 32'd0);
      if (cyc >= 2 && cyc < 5) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_tag", 32'(out_tag), 32'd1);
        chk("stall_data", out_data, 32'h0000_0002);
      end
      if (cyc >= 5 && cyc < 13) begin
        chk("release_valid", 32'(out_valid), 32'd1);
        chk("release_tag", 32'(out_tag), 32'(cyc - 4));
      end
      tick();
      if (acc_fire) n_acc++;
      if (out_fire) n_out++;
    end
    chk("stall_out_count", 32'(n_out), 32'd8);
    drain();

    // Flush with two words in flight and a third offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_00AA, 5'd1, 2'b00, 5'd20);
    tick();
    drive(1'b1, 32'h0000_00BB, 5'd2, 2'b00, 5'd21);
    tick();
    drive(1'b1, 32'h0000_00CC, 5'd3, 2'b00, 5'd22);
    flush = 1'b1;
    #1;
    chk("flush_pre_valid", 32'(out_valid), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("flush_no_ghost", 32'(out_valid), 32'd0);
    end

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    drive(1'b1, 32'h1234_5678, 5'd4, 2'b00, 5'd7);
    tick();
    drive(1'b1, 32'h0F0F_0F0F, 5'd8, 2'b01, 5'd9);
    tick();
    in_valid = 1'b0;
    #1;
    chk("arst_pre_tag", 32'(out_tag), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", out_data, 32'd0);
    chk("arst_out_tag", 32'(out_tag), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    drive(1'b1, 32'h8000_0000, 5'd4, 2'b10, 5'd15);
    tick();
    chk("arst_accept", 32'(acc_fire), 32'd1);
    drain();

    // Random traffic with random backpressure and occasional flush.
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
Parametrised, pipelined barrel shifter; the next generation of the fixed left-shift-by-constant helper.
- Performs SLL/SRL/SRA by a runtime shift amount; ROR is optional.
- Splits the log2(WORD) mux levels across PIPE_STAGES register stages, with valid/ready backpressure and a pass-through tag.
- Sits in the EX stage as the shift unit, and in branch/jump target generation with a constant shamt.

Parameters:
WORD, 32, data width in bits; power of two, >= 4.
SHAMT_W, $clog2(WORD), shift-amount width; derived, do not override.
PIPE_STAGES, 2, number of register stages, 1..SHAMT_W.
TAG_W, 5, width of the opaque tag (destination register id).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous pipeline clear.
in_valid  input  1  input word present.
in_ready  output  1  shifter can accept this cycle.
in_data  input  WORD  operand.
in_shamt  input  SHAMT_W  shift amount, unsigned.
in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
in_tag  input  TAG_W  carried unchanged to the output.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts the result.
out_data  output  WORD  shifted result.
out_tag  output  TAG_W  tag of the result.

Behaviour:
- Mux level k (k = 0..SHAMT_W-1) shifts by 2^k when shamt[k] = 1.
- Level k is placed in stage floor(k*PIPE_STAGES/SHAMT_W).
- Each stage registers: data, mode, tag, the unconsumed shamt bits, and a valid bit v[s].
- Stage s advances when v[s] = 1 and (stage s+1 is empty or advancing). The last stage advances on out_ready.
- in_ready = !v[0] | advance[0]. This is combinational from out_ready through the stage chain; there is no skid buffer.
- Transfer occurs on valid & ready at each end.
- Latency: PIPE_STAGES cycles from input accept to out_valid when there is no backpressure. Throughput: 1 word/cycle.
- out_valid = v[last]; out_data and out_tag come from the last-stage registers.
- While out_valid = 1 and out_ready = 0, out_data and out_tag hold stable.
- Results leave strictly in acceptance order; no word is dropped or duplicated.
- Arithmetic:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with in_data[WORD-1], captured at accept.
  - shamt = 0 passes the data unchanged in all modes.
- Reset (asynchronous, any time including mid-operation): all v[] = 0, so out_valid = 0. Data, tag and shamt registers reset to 0, so out_data = 0 and out_tag = 0. in_ready = 1 in the first cycle after release.
- flush: all v[] = 0 at the next edge. A word offered on in_valid in the flush cycle is discarded. Data registers are don't-care.
- Simultaneous flush and out_ready: flush wins; the output word is still considered consumed for that cycle.
- When a stage is not loaded, its data registers hold their value.

Optional Feature:
Macro SHIFTER_PIPE_ROTATE_EN.
- Defined: mode 11 = rotate right, out = (d >> n) | (d << (WORD-n)); n = 0 gives d.
- Not defined: no rotate hardware; mode 11 behaves exactly as SLL. in_mode[1:0] is still a 2-bit port.

Decomposition:
- Package shifter_pkg holds:
  - shift_mode_t enum with SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b10, SH_ROR = 2'b11;
  - localparam SH_MODE_W = 2;
  - function stage_of_level(k, SHAMT_W, PIPE_STAGES).
- One sub-module, shifter_level: combinational single mux level. Parameters WORD and DIST (= 2^k); inputs data, en, mode; output data. It is instantiated SHAMT_W times via generate.

Test Plan:
- SLL 0x0000_0001 shamt 2, out_ready = 1 -> out_data 0x0000_0004 exactly 2 cycles after accept (the constant-offset branch case).
- SRA 0x8000_0000 shamt 31 -> 0xFFFF_FFFF; SRL same operands -> 0x0000_0001; SRA 0x7FFF_FFFF shamt 31 -> 0x0000_0000.
- Back-to-back inputs, tags 1..8, with out_ready = 0 for 5 cycles:
  - in_ready drops after 2 accepts;
  - out_data/out_tag stay stable while stalled;
  - after release, tags emerge 1..8 in order, one per cycle.
- flush while 2 words are in flight and in_valid = 1 -> out_valid = 0 next cycle; none of the 3 words ever appears.
- rst_n asserted asynchronously mid-stall -> out_valid, out_data, out_tag are 0 immediately; in_ready = 1 after release; the next word computes correctly.
- SHIFTER_PIPE_ROTATE_EN defined: ROR 0x0000_00F1 shamt 4 -> 0x1000_000F. Not defined: the same stimulus -> 0x0000_0F10 (SLL).
